// File: rtl/gpio_irq_apb.sv
// APB GPIO peripheral: output pins, synchronised inputs with edge interrupts, 7-seg digit drive.
// Optional per-input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_apb #(
    parameter int unsigned N_OUT           = 16,
    parameter int unsigned N_IN            = 16,
    parameter int unsigned N_DIGITS        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           in_paddr,
    input  logic                  in_psel,
    input  logic                  in_penable,
    input  logic [2:0]            in_pprot,
    input  logic                  in_pwrite,
    input  logic [31:0]           in_pwdata,
    input  logic [3:0]            in_pstrb,
    output logic                  in_pready,
    output logic [31:0]           in_prdata,
    output logic                  in_pslverr,
    output logic [N_OUT-1:0]      gpio_out,
    input  logic [N_IN-1:0]       gpio_in,
    output logic [8*N_DIGITS-1:0] gpio_seg,
    output logic                  irq
);

    localparam int unsigned SEG_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [2:0] OFF_OUT   = 3'd0;
    localparam logic [2:0] OFF_IN    = 3'd1;
    localparam logic [2:0] OFF_SEG   = 3'd2;
    localparam logic [2:0] OFF_BLANK = 3'd3;
    localparam logic [2:0] OFF_EN    = 3'd4;
    localparam logic [2:0] OFF_STAT  = 3'd5;
    localparam logic [2:0] OFF_EDGE  = 3'd6;

    logic [N_OUT-1:0]    out_q;
    logic [SEG_W-1:0]    seg_q;
    logic [N_DIGITS-1:0] blank_q;
    logic [N_IN-1:0]     en_q;
    logic [N_IN-1:0]     stat_q;
    logic [N_IN-1:0]     edge_q;
    logic [N_IN-1:0]     sync1_q;
    logic [N_IN-1:0]     sync2_q;
    logic [N_IN-1:0]     prev_q;
    logic [N_IN-1:0]     edge_src;
    logic [N_IN-1:0]     event_c;
    logic [N_IN-1:0]     clr_c;
    logic [2:0]          offset;
    logic                access;
    logic                wr_en;
    logic [31:0]         byte_mask;

    logic unused_ok;
    assign unused_ok = ^{in_pprot, in_paddr[31:5], in_paddr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [31:0] mask);
        return (old & ~mask) | (wdata & mask);
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = 7'h7E;  4'h1: c = 7'h30;  4'h2: c = 7'h6D;  4'h3: c = 7'h79;
            4'h4: c = 7'h33;  4'h5: c = 7'h5B;  4'h6: c = 7'h5F;  4'h7: c = 7'h70;
            4'h8: c = 7'h7F;  4'h9: c = 7'h7B;  4'hA: c = 7'h77;  4'hB: c = 7'h1F;
            4'hC: c = 7'h4E;  4'hD: c = 7'h3D;  4'hE: c = 7'h4F;  default: c = 7'h47;
        endcase
        return c;
    endfunction

    assign offset    = in_paddr[4:2];
    assign access    = in_psel & in_penable;
    assign wr_en     = access & in_pwrite;
    assign byte_mask = {{8{in_pstrb[3]}}, {8{in_pstrb[2]}}, {8{in_pstrb[1]}}, {8{in_pstrb[0]}}};
    assign in_pready = access;
    assign gpio_out  = out_q;
    assign irq       = |(stat_q & en_q);

    // Read mux and unmapped-offset error, combinational during the access phase
    always_comb begin
        in_prdata  = '0;
        in_pslverr = 1'b0;
        if (access) begin
            in_pslverr = (offset == 3'd7);
            if (!in_pwrite) begin
                case (offset)
                    OFF_OUT:   in_prdata = 32'(out_q);
                    OFF_IN:    in_prdata = 32'(sync2_q);
                    OFF_SEG:   in_prdata = 32'(seg_q);
                    OFF_BLANK: in_prdata = 32'(blank_q);
                    OFF_EN:    in_prdata = 32'(en_q);
                    OFF_STAT:  in_prdata = 32'(stat_q);
                    OFF_EDGE:  in_prdata = 32'(edge_q);
                    default:   in_prdata = '0;
                endcase
            end
        end
    end

    // Event detection and W1C clear mask; a same-cycle event overrides the clear
    always_comb begin
        event_c = ((~prev_q & edge_src) & ~edge_q) | ((prev_q & ~edge_src) & edge_q);
        clr_c   = '0;
        if (wr_en && offset == OFF_STAT) begin
            clr_c = N_IN'(in_pwdata & byte_mask);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q   <= '0;
            seg_q   <= '0;
            blank_q <= '0;
            en_q    <= '0;
            edge_q  <= '0;
            stat_q  <= '0;
        end else begin
            stat_q <= (stat_q & ~clr_c) | event_c;
            if (wr_en) begin
                case (offset)
                    OFF_OUT:   out_q   <= N_OUT'(merge(32'(out_q), in_pwdata, byte_mask));
                    OFF_SEG:   seg_q   <= SEG_W'(merge(32'(seg_q), in_pwdata, byte_mask));
                    OFF_BLANK: blank_q <= N_DIGITS'(merge(32'(blank_q), in_pwdata, byte_mask));
                    OFF_EN:    en_q    <= N_IN'(merge(32'(en_q), in_pwdata, byte_mask));
                    OFF_EDGE:  edge_q  <= N_IN'(merge(32'(edge_q), in_pwdata, byte_mask));
                    default:   ;
                endcase
            end
        end
    end

    // Two-flop synchroniser and previous-value register for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= edge_src;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [CNT_W-1:0] db_cnt_q [N_IN];
    logic [N_IN-1:0]  db_state_q;

    // A bit follows sync2 only after DEBOUNCE_CYCLES consecutive mismatching cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            db_state_q <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2_q[i] == db_state_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_state_q[i] <= sync2_q[i];
                    db_cnt_q[i]   <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign edge_src = db_state_q;
`else
    logic [CNT_W-1:0] unused_db_cnt;
    assign unused_db_cnt = '0;
    assign edge_src      = sync2_q;
`endif

    // Active-low segment drive; blanked digits are all-off
    always_comb begin
        gpio_seg = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            gpio_seg[8*k +: 8] = blank_q[k] ? 8'hFF : ~{seg_code(seg_q[4*k +: 4]), 1'b0};
        end
    end

endmodule

// File: tb/tb_gpio_irq_apb.sv
// Self-checking bench for gpio_irq_apb: directed scenarios plus randomized register and interrupt traffic.
module tb_gpio_irq_apb;

    localparam int unsigned N_OUT = 16;
    localparam int unsigned N_IN = 16;
    localparam int unsigned N_DIGITS = 8;
    localparam logic [6:0] CODES [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                  reset;
    logic [31:0]           paddr, pwdata, prdata;
    logic                  psel, penable, pwrite, pready, pslverr, irq;
    logic [2:0]            pprot;
    logic [3:0]            pstrb;
    logic [N_OUT-1:0]      gpio_out;
    logic [N_IN-1:0]       gpio_in;
    logic [8*N_DIGITS-1:0] gpio_seg;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_out, m_seg, m_blank, m_en, m_stat, m_edge;

    gpio_irq_apb #(.N_OUT(N_OUT), .N_IN(N_IN), .N_DIGITS(N_DIGITS), .DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .in_paddr(paddr), .in_psel(psel), .in_penable(penable),
        .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
        .in_pready(pready), .in_prdata(prdata), .in_pslverr(pslverr), .gpio_out(gpio_out),
        .gpio_in(gpio_in), .gpio_seg(gpio_seg), .irq(irq)
    );

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        return (old & ~bmask(s)) | (d & bmask(s));
    endfunction

    function automatic logic [63:0] exp_seg();
        logic [63:0] r;
        logic [3:0] n;
        for (int k = 0; k < 8; k++) begin
            n = m_seg[4*k +: 4];
            r[8*k +: 8] = m_blank[k] ? 8'hFF : ~{CODES[n], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [2:0] off, input logic [15:0] pins);
        case (off)
            3'd0: return m_out;
            3'd1: return {16'h0, pins};
            3'd2: return m_seg;
            3'd3: return m_blank;
            3'd4: return m_en;
            3'd5: return m_stat;
            3'd6: return m_edge;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_out = 0; m_seg = 0; m_blank = 0; m_en = 0; m_stat = 0; m_edge = 0;
    endtask

    task automatic bus_idle();
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    endtask

    // APB write through both phases; updates the register model for non-event state
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clock);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d; pstrb = s;
        @(negedge clock);
        penable = 1;
        @(negedge clock);
        bus_idle();
        case (a[4:2])
            3'd0: m_out = merge(m_out, d, s) & 32'hFFFF;
            3'd2: m_seg = merge(m_seg, d, s);
            3'd3: m_blank = merge(m_blank, d, s) & 32'hFF;
            3'd4: m_en = merge(m_en, d, s) & 32'hFFFF;
            3'd5: m_stat = m_stat & ~(d & bmask(s));
            3'd6: m_edge = merge(m_edge, d, s) & 32'hFFFF;
            default: ;
        endcase
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic e, output logic r);
        @(negedge clock);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(negedge clock);
        penable = 1;
        #1;
        d = prdata; e = pslverr; r = pready;
        @(negedge clock);
        bus_idle();
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e, r;
        reset = 1; bus_idle(); pprot = 0; gpio_in = 0;
        repeat (3) @(negedge clock);
        reset = 0;
        model_reset();
        #1;
        checks++; if (gpio_out !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", gpio_out); end
        checks++; if (gpio_seg !== {8{8'h03}}) begin failures++; $display("FAIL reset_seg got=%h exp=%h", gpio_seg, {8{8'h03}}); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (prdata !== 32'h0 || pready !== 1'b0) begin failures++; $display("FAIL idle_bus prdata=%h pready=%b exp 0/0", prdata, pready); end
        for (int o = 0; o < 7; o++) begin
            rd(32'(o * 4), d, e, r);
            checks++; if (d !== 32'h0 || e !== 1'b0 || r !== 1'b1) begin failures++; $display("FAIL reset_reg%0d data=%h err=%b rdy=%b exp 0/0/1", o, d, e, r); end
        end
    endtask

    task automatic test_spec_vectors();
        logic [31:0] d; logic e, r;
        wr(32'h00, 32'h1234ABCD, 4'b0011);
        checks++; if (gpio_out !== 16'hABCD) begin failures++; $display("FAIL strb_out got=%h exp=abcd", gpio_out); end
        rd(32'h00, d, e, r);
        checks++; if (d !== 32'h0000ABCD || e !== 1'b0) begin failures++; $display("FAIL strb_read got=%h err=%b exp=0000abcd/0", d, e); end
        rd(32'h1C, d, e, r);
        checks++; if (d !== 32'h0 || e !== 1'b1) begin failures++; $display("FAIL unmapped_read got=%h err=%b exp=0/1", d, e); end
        wr(32'h04, 32'hFFFFFFFF, 4'hF);
        rd(32'h04, d, e, r);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL in_write_ignored got=%h err=%b exp=0/0", d, e); end
        wr(32'h08, 32'h76543210, 4'hF);
        wr(32'h0C, 32'h00000080, 4'hF);
        checks++; if (gpio_seg[7:0] !== 8'h03) begin failures++; $display("FAIL digit0 got=%h exp=03", gpio_seg[7:0]); end
        checks++; if (gpio_seg[15:8] !== 8'h9F) begin failures++; $display("FAIL digit1 got=%h exp=9f", gpio_seg[15:8]); end
        checks++; if (gpio_seg[63:56] !== 8'hFF) begin failures++; $display("FAIL digit7 got=%h exp=ff", gpio_seg[63:56]); end
        checks++; if (gpio_seg !== exp_seg()) begin failures++; $display("FAIL seg_all got=%h exp=%h", gpio_seg, exp_seg()); end
    endtask

    task automatic test_rise_irq();
        logic [31:0] d; logic e, r;
        wr(32'h18, 32'h0, 4'hF);
        wr(32'h10, 32'h1, 4'hF);
        wr(32'h14, 32'hFFFF, 4'hF);
        repeat (3) @(negedge clock);
`ifndef GPIO_DEBOUNCE_EN
        gpio_in[0] = 1'b1;
        @(negedge clock);
        psel = 1; penable = 0; pwrite = 0; paddr = 32'h04;
        @(negedge clock);
        penable = 1;
        #1;
        checks++; if (prdata !== 32'h1) begin failures++; $display("FAIL in_latency got=%h exp=1", prdata); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clock);
        bus_idle();
        m_stat = m_stat | 32'h1;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_latency got=%b exp=1", irq); end
`else
        gpio_in[0] = 1'b1;
        repeat (14) @(negedge clock);
        m_stat = m_stat | 32'h1;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_debounced_rise got=%b exp=1", irq); end
`endif
        rd(32'h14, d, e, r);
        checks++; if (d !== m_stat) begin failures++; $display("FAIL stat_rise got=%h exp=%h", d, m_stat); end
        wr(32'h14, 32'h1, 4'hF);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
    endtask

    task automatic test_fall_masked();
        logic [31:0] d; logic e, r;
        wr(32'h18, 32'h8, 4'hF);
        wr(32'h10, 32'h1, 4'hF);
        gpio_in[3] = 1'b1;
        repeat (14) @(negedge clock);
        wr(32'h14, 32'hFFFF, 4'hF);
        gpio_in[3] = 1'b0;
        repeat (14) @(negedge clock);
        m_stat = m_stat | 32'h8;
        rd(32'h14, d, e, r);
        checks++; if (d !== 32'h8) begin failures++; $display("FAIL fall_stat got=%h exp=8", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_masked_irq got=%b exp=0", irq); end
        wr(32'h10, 32'h9, 4'hF);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fall_unmasked_irq got=%b exp=1", irq); end
        wr(32'h14, 32'hFFFF, 4'hF);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_clear_irq got=%b exp=0", irq); end
    endtask

    task automatic test_set_beats_clear();
`ifndef GPIO_DEBOUNCE_EN
        logic [31:0] d; logic e, r;
        wr(32'h18, 32'h0, 4'hF);
        gpio_in[0] = 1'b0;
        repeat (6) @(negedge clock);
        wr(32'h14, 32'hFFFF, 4'hF);
        gpio_in[0] = 1'b1;
        @(negedge clock);
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'h1; pstrb = 4'hF;
        @(negedge clock);
        penable = 1;
        @(negedge clock);
        bus_idle();
        m_stat = 32'h1;
        rd(32'h14, d, e, r);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL set_beats_clear got=%h exp=1", d); end
        wr(32'h14, 32'h1, 4'hF);
        rd(32'h14, d, e, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL plain_w1c got=%h exp=0", d); end
`endif
    endtask

    task automatic test_debounce();
        logic [31:0] d; logic e, r;
        wr(32'h18, 32'h0, 4'hF);
        wr(32'h10, 32'h4, 4'hF);
        gpio_in[2] = 1'b0;
        repeat (14) @(negedge clock);
        wr(32'h14, 32'hFFFF, 4'hF);
`ifdef GPIO_DEBOUNCE_EN
        gpio_in[2] = 1'b1;
        repeat (3) @(negedge clock);
        gpio_in[2] = 1'b0;
        repeat (14) @(negedge clock);
        rd(32'h14, d, e, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL glitch_filtered got=%h exp=0", d); end
        gpio_in[2] = 1'b1;
        repeat (6) @(negedge clock);
        gpio_in[2] = 1'b0;
        repeat (16) @(negedge clock);
        rd(32'h14, d, e, r);
        checks++; if (d !== 32'h4 || irq !== 1'b1) begin failures++; $display("FAIL pulse_stat got=%h irq=%b exp=4/1", d, irq); end
        wr(32'h14, 32'h4, 4'hF);
        repeat (14) @(negedge clock);
        rd(32'h14, d, e, r);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL pulse_once got=%h exp=0", d); end
`else
        gpio_in[2] = 1'b1;
        @(negedge clock);
        gpio_in[2] = 1'b0;
        repeat (6) @(negedge clock);
        rd(32'h14, d, e, r);
        checks++; if (d !== 32'h4 || irq !== 1'b1) begin failures++; $display("FAIL glitch_seen got=%h irq=%b exp=4/1", d, irq); end
        wr(32'h14, 32'h4, 4'hF);
`endif
        m_stat = 0;
    endtask

    // Per-cycle random pin toggles and W1C traffic against a history-based event model
    task automatic test_random_irq();
`ifndef GPIO_DEBOUNCE_EN
        logic [15:0] hist[$];
        logic [15:0] cur, prv, ev, clr;
        logic [31:0] d; logic e, r;
        int phase;
        gpio_in = 16'($urandom);
        repeat (4) @(negedge clock);
        wr(32'h18, 32'($urandom_range(0, 65535)), 4'hF);
        wr(32'h10, 32'($urandom_range(0, 65535)), 4'hF);
        wr(32'h14, 32'hFFFF, 4'hF);
        hist = '{gpio_in, gpio_in, gpio_in};
        phase = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clock);
            checks++; if (irq !== |(m_stat & m_en)) begin failures++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", cyc, irq, |(m_stat & m_en)); end
            if (cyc < 280 && $urandom_range(0, 2) == 0) gpio_in = gpio_in ^ 16'($urandom);
            if (phase == 0 && cyc < 285 && $urandom_range(0, 3) == 0) begin
                psel = 1; penable = 0; pwrite = 1; paddr = 32'h14;
                pwdata = $urandom; pstrb = 4'($urandom_range(0, 15)); phase = 1;
            end else if (phase == 1) begin
                penable = 1; phase = 2;
            end else if (phase == 2) begin
                bus_idle(); phase = 0;
            end
            @(posedge clock);
            hist.push_back(gpio_in);
            cur = hist[hist.size() - 3];
            prv = hist[hist.size() - 4];
            ev = (~prv & cur & ~m_edge[15:0]) | (prv & ~cur & m_edge[15:0]);
            clr = (psel && penable && pwrite && paddr[4:2] == 3'd5) ? 16'(pwdata & bmask(pstrb)) : 16'h0;
            m_stat = 32'((m_stat[15:0] & ~clr) | ev);
        end
        bus_idle();
        rd(32'h14, d, e, r);
        checks++; if (d !== m_stat) begin failures++; $display("FAIL rand_stat got=%h exp=%h", d, m_stat); end
`endif
    endtask

    task automatic test_random_regs();
        logic [31:0] d, wd; logic e, r;
        logic [2:0] off;
        logic [3:0] s;
        for (int i = 0; i < 40; i++) begin
            off = 3'($urandom_range(0, 7));
            wd = $urandom;
            s = 4'($urandom_range(0, 15));
            if (off == 3'd5 && $urandom_range(0, 1) == 0) s = 4'h0;
            wr(32'(off) << 2, wd, s);
            rd(32'(off) << 2, d, e, r);
            checks++;
            if (d !== exp_reg(off, gpio_in) || e !== (off == 3'd7) || r !== 1'b1) begin
                failures++; $display("FAIL rand_reg off=%0d got=%h err=%b rdy=%b exp=%h", off, d, e, r, exp_reg(off, gpio_in));
            end
            checks++;
            if (gpio_out !== m_out[15:0] || gpio_seg !== exp_seg() || irq !== |(m_stat & m_en)) begin
                failures++; $display("FAIL rand_pins out=%h seg=%h irq=%b exp=%h/%h/%b", gpio_out, gpio_seg, irq, m_out[15:0], exp_seg(), |(m_stat & m_en));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d; logic e, r;
        wr(32'h00, 32'hFFFF, 4'hF);
        wr(32'h08, 32'h89ABCDEF, 4'hF);
        wr(32'h10, 32'hFFFF, 4'hF);
        wr(32'h18, 32'h0, 4'hF);
        gpio_in = 0;
        repeat (6) @(negedge clock);
        gpio_in[2] = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1; gpio_in = 0;
        @(negedge clock);
        reset = 0;
        model_reset();
        #1;
        checks++; if (gpio_out !== 16'h0 || gpio_seg !== {8{8'h03}} || irq !== 1'b0) begin failures++; $display("FAIL midreset_pins out=%h seg=%h irq=%b", gpio_out, gpio_seg, irq); end
        repeat (14) @(negedge clock);
        for (int o = 0; o < 7; o++) begin
            rd(32'(o * 4), d, e, r);
            checks++; if (d !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL midreset_reg%0d got=%h err=%b exp=0/0", o, d, e); end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_rise_irq();
        test_fall_masked();
        test_set_beats_clear();
        test_debounce();
        test_random_irq();
        test_random_regs();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
